// File: rtl/pipe_rate_change_ctrl_pkg.sv
// Shared types and constants for PIPE rate change sequencing.
// Used by the rate change controller and its lane status collector.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        QUIESCE,
        SET_RATE,
        ACK,
        RELEASE,
        DONE
    } rc_state_e;

    localparam logic [3:0] RATE_GEN1 = 4'b0001;
    localparam logic [3:0] RATE_GEN2 = 4'b0010;
    localparam logic [3:0] RATE_GEN3 = 4'b0011;
    localparam logic [3:0] RATE_GEN4 = 4'b0100;
    localparam logic [3:0] RATE_GEN5 = 4'b0101;

    localparam int DEF_QUIESCE_CYCLES = 8;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

    function automatic logic isSameRate(
        input logic [3:0] reqRate,
        input logic [4:0] reqPclk,
        input logic [3:0] curRate,
        input logic [4:0] curPclk
    );
        return (reqRate == curRate) && (reqPclk == curPclk);
    endfunction

endpackage

// File: rtl/pipe_lane_status_collector.sv
// Sticky per-lane status mask; all_seen includes the current cycle's pulses
// so a sequencer can leave its wait state on the same cycle the last lane reports.
module pipe_lane_status_collector
    import pipe_ctrl_pkg::*;
#(
    parameter int LANES = 16
) (
    input  logic             PCLK,
    input  logic             phy_reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic [LANES-1:0] status,
    output logic             all_seen
);

    logic [LANES-1:0] mask;
    logic [LANES-1:0] maskNext;

    // OR in this cycle's pulses while collecting
    always_comb begin
        maskNext = mask;
        if (en) begin
            maskNext = mask | status;
        end
    end

    assign all_seen = &maskNext;

    // Hold the sticky mask; clear wins over collection
    always_ff @(posedge PCLK) begin
        if (!phy_reset_n || clr) begin
            mask <= '0;
        end else begin
            mask <= maskNext;
        end
    end

endmodule

// File: rtl/pipe_rate_change_ctrl.sv
// MAC-side PIPE rate / PCLK rate change sequencer.
// Quiesces Tx, drives Rate/PCLKRate, then runs the PclkChangeOk/Ack/PhyStatus handshake.
module pipe_rate_change_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int         LANESNUMBER    = 16,
    parameter int         QUIESCE_CYCLES = DEF_QUIESCE_CYCLES,
    parameter int         TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter logic [3:0] RESET_RATE     = RATE_GEN1
) (
    input  logic                   PCLK,
    input  logic                   phy_reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [3:0]             req_rate,
    input  logic [4:0]             req_pclkrate,
    output logic [3:0]             Rate,
    output logic [4:0]             PCLKRate,
    input  logic                   PclkChangeOk,
    output logic                   PclkChangeAck,
    input  logic [LANESNUMBER-1:0] PhyStatus,
    output logic                   tx_elec_idle_force,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout_err
);

    localparam int              TW     = $clog2(TIMEOUT_CYCLES);
    localparam logic [7:0]      Q_LAST = 8'(QUIESCE_CYCLES - 1);
    localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT_CYCLES - 1);

    rc_state_e      state;
    rc_state_e      stateNext;
    logic [3:0]     tgtRate;
    logic [4:0]     tgtPclkRate;
    logic [7:0]     qCnt;
    logic [TW-1:0]  tmoCnt;
    logic           timeoutHit;
    logic           allSeen;
    logic           inWait;

    assign busy      = (state != IDLE);
    assign req_ready = !busy;
    assign done      = (state == DONE);
    assign inWait    = (state == SET_RATE) || (state == ACK);

    assign tx_elec_idle_force = (state == QUIESCE) || (state == SET_RATE)
                             || (state == ACK) || (state == RELEASE);

    pipe_lane_status_collector #(
        .LANES(LANESNUMBER)
    ) u_collector (
        .PCLK       (PCLK),
        .phy_reset_n(phy_reset_n),
        .clr        (state != ACK),
        .en         (state == ACK),
        .status     (PhyStatus),
        .all_seen   (allSeen)
    );

    // Next-state decode and timeout detection
    always_comb begin
        stateNext  = state;
        timeoutHit = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    stateNext = isSameRate(req_rate, req_pclkrate, Rate, PCLKRate)
                              ? DONE : QUIESCE;
                end
            end
            QUIESCE: begin
                if (qCnt == Q_LAST) begin
                    stateNext = SET_RATE;
                end
            end
            SET_RATE: begin
                if (PclkChangeOk) begin
                    stateNext = ACK;
                end else if (tmoCnt == T_LAST) begin
                    stateNext  = IDLE;
                    timeoutHit = 1'b1;
                end
            end
            ACK: begin
                if (allSeen && !PclkChangeOk) begin
                    stateNext = RELEASE;
                end else if (tmoCnt == T_LAST) begin
                    stateNext  = IDLE;
                    timeoutHit = 1'b1;
                end
            end
            RELEASE: stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // State, counters and registered PIPE outputs
    always_ff @(posedge PCLK) begin
        if (!phy_reset_n) begin
            state         <= IDLE;
            Rate          <= RESET_RATE;
            PCLKRate      <= '0;
            PclkChangeAck <= 1'b0;
            timeout_err   <= 1'b0;
            tgtRate       <= '0;
            tgtPclkRate   <= '0;
            qCnt          <= '0;
            tmoCnt        <= '0;
        end else begin
            state         <= stateNext;
            timeout_err   <= timeoutHit;
            PclkChangeAck <= (stateNext == ACK);
            if (state == IDLE && req_valid) begin
                tgtRate     <= req_rate;
                tgtPclkRate <= req_pclkrate;
            end
            qCnt <= (state == QUIESCE) ? qCnt + 8'd1 : 8'd0;
            if (!inWait || stateNext != state) begin
                tmoCnt <= '0;
            end else begin
                tmoCnt <= tmoCnt + 1'b1;
            end
            if (state == QUIESCE && stateNext == SET_RATE) begin
                Rate     <= tgtRate;
                PCLKRate <= tgtPclkRate;
            end
        end
    end

endmodule

// File: tb/tb_pipe_rate_change_ctrl.sv
// Directed bench for pipe_rate_change_ctrl.
// Table of full rate changes plus staggered, timeout, reset and back-pressure sequences.
module tb_pipe_rate_change_ctrl;

    logic        PCLK = 1'b0;
    logic        phy_reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_rate;
    logic [4:0]  req_pclkrate;
    logic [3:0]  Rate;
    logic [4:0]  PCLKRate;
    logic        PclkChangeOk;
    logic        PclkChangeAck;
    logic [15:0] PhyStatus;
    logic        tx_elec_idle_force;
    logic        busy;
    logic        done;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    always #5 PCLK = ~PCLK;

    pipe_rate_change_ctrl dut (
        .PCLK              (PCLK),
        .phy_reset_n       (phy_reset_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_rate          (req_rate),
        .req_pclkrate      (req_pclkrate),
        .Rate              (Rate),
        .PCLKRate          (PCLKRate),
        .PclkChangeOk      (PclkChangeOk),
        .PclkChangeAck     (PclkChangeAck),
        .PhyStatus         (PhyStatus),
        .tx_elec_idle_force(tx_elec_idle_force),
        .busy              (busy),
        .done              (done),
        .timeout_err       (timeout_err)
    );

    typedef struct {
        logic [3:0] rate;
        logic [4:0] pclk;
        int         okDelay;
        int         expRateAt;
        int         expAckAt;
        int         expDoneAt;
        int         expForce;
        int         expAckCnt;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic runChange(input int idx, input vec_t v);
        int n;
        int rateAt;
        int ackAt;
        int doneAt;
        int doneCnt;
        int forceCnt;
        int ackCnt;
        int tmoCnt;
        int forceAtDone;
        logic [8:0] prev;
        prev = {Rate, PCLKRate};
        rateAt = -1; ackAt = -1; doneAt = -1;
        doneCnt = 0; forceCnt = 0; ackCnt = 0; tmoCnt = 0; forceAtDone = 0;
        chk($sformatf("row%0d ready", idx), req_ready, 1);
        req_valid = 1'b1;
        req_rate = v.rate;
        req_pclkrate = v.pclk;
        @(negedge PCLK);
        req_valid = 1'b0;
        n = 1;
        while (n < 100 && doneAt < 0) begin
            if (rateAt < 0 && {Rate, PCLKRate} != prev) rateAt = n;
            if (rateAt < 0 && tx_elec_idle_force) forceCnt++;
            if (PclkChangeAck) begin
                ackCnt++;
                if (ackAt < 0) ackAt = n;
            end
            if (timeout_err) tmoCnt++;
            if (done) begin
                doneCnt++;
                doneAt = n;
                forceAtDone = int'(tx_elec_idle_force);
            end
            PhyStatus = '0;
            if (rateAt >= 0 && n == rateAt + v.okDelay) PclkChangeOk = 1'b1;
            if (PclkChangeAck && PclkChangeOk) begin
                PhyStatus = '1;
                PclkChangeOk = 1'b0;
            end
            @(negedge PCLK);
            n++;
        end
        chk($sformatf("row%0d done_at", idx), doneAt, v.expDoneAt);
        chk($sformatf("row%0d done_cnt", idx), doneCnt, 1);
        chk($sformatf("row%0d rate_at", idx), rateAt, v.expRateAt);
        chk($sformatf("row%0d ack_at", idx), ackAt, v.expAckAt);
        chk($sformatf("row%0d ack_cnt", idx), ackCnt, v.expAckCnt);
        chk($sformatf("row%0d force_pre", idx), forceCnt, v.expForce);
        chk($sformatf("row%0d force_done", idx), forceAtDone, 0);
        chk($sformatf("row%0d tmo", idx), tmoCnt, 0);
        chk($sformatf("row%0d rate", idx), Rate, v.rate);
        chk($sformatf("row%0d pclk", idx), PCLKRate, v.pclk);
        chk($sformatf("row%0d idle_after", idx), busy, 0);
        chk($sformatf("row%0d done_after", idx), done, 0);
    endtask

    task automatic serviceUntilDone(input logic [3:0] r, input logic [4:0] p,
                                    output int doneAt);
        bit acked;
        acked = 1'b0;
        doneAt = -1;
        for (int n = 1; n <= 100 && doneAt < 0; n++) begin
            PhyStatus = '0;
            if (done) begin
                doneAt = n;
            end else if (!acked && PclkChangeAck && PclkChangeOk) begin
                PhyStatus = '1;
                PclkChangeOk = 1'b0;
                acked = 1'b1;
            end else if (!acked && Rate == r && PCLKRate == p && tx_elec_idle_force) begin
                PclkChangeOk = 1'b1;
            end
            if (doneAt < 0) @(negedge PCLK);
        end
    endtask

    initial begin
        int n;
        int doneCnt;
        int doneAt;
        int evCnt;

        vecs[0] = '{4'd1, 5'd0, 0, -1, -1,  1, 0, 0};
        vecs[1] = '{4'd3, 5'd2, 3,  9, 13, 15, 8, 1};
        vecs[2] = '{4'd4, 5'd3, 0,  9, 10, 12, 8, 1};
        vecs[3] = '{4'd4, 5'd3, 0, -1, -1,  1, 0, 0};
        vecs[4] = '{4'd4, 5'd1, 1,  9, 11, 13, 8, 1};

        phy_reset_n  = 1'b0;
        req_valid    = 1'b0;
        req_rate     = '0;
        req_pclkrate = '0;
        PclkChangeOk = 1'b0;
        PhyStatus    = '0;
        repeat (3) @(negedge PCLK);
        chk("rst rate", Rate, 1);
        chk("rst pclk", PCLKRate, 0);
        chk("rst ack", PclkChangeAck, 0);
        chk("rst force", tx_elec_idle_force, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst tmo", timeout_err, 0);
        phy_reset_n = 1'b1;
        @(negedge PCLK);
        chk("rst ready", req_ready, 1);

        for (int i = 0; i < 5; i++) begin
            runChange(i, vecs[i]);
        end

        // Staggered lanes: Rate 4/1 -> 2/1
        req_valid = 1'b1;
        req_rate = 4'd2;
        req_pclkrate = 5'd1;
        @(negedge PCLK);
        req_valid = 1'b0;
        n = 0;
        while (!PclkChangeAck && n < 50) begin
            if (Rate == 4'd2) PclkChangeOk = 1'b1;
            @(negedge PCLK);
            n++;
        end
        chk("stag ack_bound", n < 50, 1);
        doneCnt = 0;
        doneAt = -1;
        for (int k = 0; k < 10; k++) begin
            if (done) begin
                doneCnt++;
                doneAt = k;
            end
            if (k == 5) chk("stag ack_hold", PclkChangeAck, 1);
            if (k == 6) chk("stag ack_drop", PclkChangeAck, 0);
            if (k == 6) chk("stag force_rel", tx_elec_idle_force, 1);
            PhyStatus = '0;
            if (k == 0) PhyStatus = 16'h00FF;
            if (k == 2) PclkChangeOk = 1'b0;
            if (k == 5) PhyStatus = 16'hFF00;
            @(negedge PCLK);
        end
        chk("stag done_cnt", doneCnt, 1);
        chk("stag done_at", doneAt, 7);

        // Timeout in SET_RATE: PHY never raises Ok
        req_valid = 1'b1;
        req_rate = 4'd3;
        req_pclkrate = 5'd2;
        @(negedge PCLK);
        req_valid = 1'b0;
        n = 1;
        evCnt = 0;
        while (!timeout_err && n < 5000) begin
            if (done || PclkChangeAck) evCnt++;
            @(negedge PCLK);
            n++;
        end
        chk("tmo at", n, 4105);
        chk("tmo ack", PclkChangeAck, 0);
        chk("tmo force", tx_elec_idle_force, 0);
        chk("tmo ready", req_ready, 1);
        chk("tmo rate", Rate, 3);
        chk("tmo pclk", PCLKRate, 2);
        chk("tmo no_done", evCnt, 0);
        @(negedge PCLK);
        chk("tmo pulse", timeout_err, 0);

        // Reset while Ack is high
        req_valid = 1'b1;
        req_rate = 4'd4;
        req_pclkrate = 5'd2;
        @(negedge PCLK);
        req_valid = 1'b0;
        n = 0;
        while (!PclkChangeAck && n < 50) begin
            if (Rate == 4'd4) PclkChangeOk = 1'b1;
            @(negedge PCLK);
            n++;
        end
        chk("mrst ack_bound", n < 50, 1);
        phy_reset_n = 1'b0;
        @(negedge PCLK);
        chk("mrst rate", Rate, 1);
        chk("mrst pclk", PCLKRate, 0);
        chk("mrst ack", PclkChangeAck, 0);
        chk("mrst busy", busy, 0);
        chk("mrst force", tx_elec_idle_force, 0);
        phy_reset_n = 1'b1;
        PclkChangeOk = 1'b0;
        evCnt = 0;
        repeat (5) begin
            if (done || timeout_err) evCnt++;
            @(negedge PCLK);
        end
        chk("mrst no_pulse", evCnt, 0);

        // Back-pressure: valid held with a changing target
        req_valid = 1'b1;
        req_rate = 4'd3;
        req_pclkrate = 5'd1;
        @(negedge PCLK);
        req_rate = 4'd5;
        req_pclkrate = 5'd4;
        serviceUntilDone(4'd3, 5'd1, doneAt);
        chk("bp1 done_at", doneAt, 12);
        chk("bp1 rate", Rate, 3);
        chk("bp1 pclk", PCLKRate, 1);
        @(negedge PCLK);
        chk("bp2 ready", req_ready, 1);
        @(negedge PCLK);
        chk("bp2 busy", busy, 1);
        req_valid = 1'b0;
        serviceUntilDone(4'd5, 5'd4, doneAt);
        chk("bp2 done_at", doneAt, 12);
        chk("bp2 rate", Rate, 5);
        chk("bp2 pclk", PCLKRate, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
